// File: rtl/tt_sweep.sv
// tt_sweep: sweeps a 7-input combinational function block through all 128
// minterms, assembles its truth table and compares it with an expected table.
// Results: match flag, mismatch count, first mismatching minterm, on-set size.
// Optional build macro TT_SWEEP_FREG_EN: registers f_in_i before comparison
// (one extra cycle of latency, compare index lags drive index by one).
module tt_sweep (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [127:0] expected_i,
    output logic         x0_o,
    output logic         x1_o,
    output logic         x2_o,
    output logic         x3_o,
    output logic         x4_o,
    output logic         x5_o,
    output logic         x6_o,
    input  logic         f_in_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [127:0] tt_o,
    output logic         match_o,
    output logic [7:0]   mismatch_cnt_o,
    output logic [6:0]   first_bad_o,
    output logic         first_bad_vld_o,
    output logic [7:0]   ones_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;       // capture-edge counter within RUN
    logic [6:0]   x_q, x_d;
    logic [127:0] exp_q, exp_d;
    logic [127:0] tt_q, tt_d;
    logic [7:0]   ones_q, ones_d;
    logic [7:0]   mis_q, mis_d;
    logic [6:0]   fb_q, fb_d;
    logic         fbv_q, fbv_d;
    logic         match_q, match_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic         cap_en_s;           // this RUN edge stores a truth-table bit
    logic [6:0]   cap_idx_s;          // minterm being stored
    logic         cap_bit_s;          // value being stored
    logic         cap_last_s;         // this RUN edge stores minterm 127
    logic         mism_s;

`ifdef TT_SWEEP_FREG_EN
    logic f_q;

    // Pipeline register on the function-block output for deep networks.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_q <= 1'b0;
        end else begin
            f_q <= f_in_i;
        end
    end

    // First RUN edge only primes f_q; minterm cnt-1 is stored afterwards.
    assign cap_en_s   = (cnt_q != 8'd0);
    assign cap_idx_s  = cnt_q[6:0] - 7'd1;
    assign cap_bit_s  = f_q;
    assign cap_last_s = (cnt_q == 8'd128);
`else
    assign cap_en_s   = 1'b1;
    assign cap_idx_s  = cnt_q[6:0];
    assign cap_bit_s  = f_in_i;
    assign cap_last_s = (cnt_q == 8'd127);
`endif

    assign mism_s = cap_bit_s ^ exp_q[cap_idx_s];

    // Next-state and datapath update for the IDLE/RUN/DONE sweep sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        exp_d   = exp_q;
        tt_d    = tt_q;
        ones_d  = ones_q;
        mis_d   = mis_q;
        fb_d    = fb_q;
        fbv_d   = fbv_q;
        match_d = match_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    cnt_d   = 8'd0;
                    x_d     = 7'd0;
                    exp_d   = expected_i;
                    tt_d    = 128'd0;
                    ones_d  = 8'd0;
                    mis_d   = 8'd0;
                    fb_d    = 7'd0;
                    fbv_d   = 1'b0;
                    match_d = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (cap_en_s) begin
                    tt_d[cap_idx_s] = cap_bit_s;
                    ones_d = ones_q + {7'd0, cap_bit_s};
                    if (mism_s) begin
                        mis_d = mis_q + 8'd1;
                        if (!fbv_q) begin
                            fb_d  = cap_idx_s;
                            fbv_d = 1'b1;
                        end else begin
                            fb_d  = fb_q;
                        end
                    end else begin
                        mis_d = mis_q;
                    end
                end else begin
                    tt_d = tt_q;
                end
                // Drive index saturates at 127 (holds there in the registered build).
                if (cnt_q >= 8'd126) begin
                    x_d = 7'd127;
                end else begin
                    x_d = cnt_q[6:0] + 7'd1;
                end
                if (cap_last_s) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    match_d = (mis_d == 8'd0);
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            x_q     <= 7'd0;
            exp_q   <= 128'd0;
            tt_q    <= 128'd0;
            ones_q  <= 8'd0;
            mis_q   <= 8'd0;
            fb_q    <= 7'd0;
            fbv_q   <= 1'b0;
            match_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            exp_q   <= exp_d;
            tt_q    <= tt_d;
            ones_q  <= ones_d;
            mis_q   <= mis_d;
            fb_q    <= fb_d;
            fbv_q   <= fbv_d;
            match_q <= match_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign x0_o            = x_q[0];
    assign x1_o            = x_q[1];
    assign x2_o            = x_q[2];
    assign x3_o            = x_q[3];
    assign x4_o            = x_q[4];
    assign x5_o            = x_q[5];
    assign x6_o            = x_q[6];
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign tt_o            = tt_q;
    assign match_o         = match_q;
    assign mismatch_cnt_o  = mis_q;
    assign first_bad_o     = fb_q;
    assign first_bad_vld_o = fbv_q;
    assign ones_cnt_o      = ones_q;

endmodule

// File: doc/tt_sweep.md
# tt_sweep

Sequential truth-table sweeper that sits directly upstream of a combinational 7-input single-output function block: it drives x0..x6 through all 128 minterms and samples the block's output. It assembles the 128-bit truth table, compares it against an expected table, and reports match status, mismatch count, first mismatching minterm and on-set size. Used to check synthesized 7-input networks against their target function in simulation and on-chip self-test.

## Interface
- No parameters; width fixed at 7 inputs / 128 minterms.
- clk  in  1  single clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a sweep; accepted only in IDLE.
- expected  in  128  target truth table; bit i = f(minterm i); latched on accepted start.
- x0..x6  out  1 each  registered drive to the function block; minterm index = {x6,...,x0}, so x0 is the LSB.
- f_in  in  1  output of the function block (combinational from x0..x6).
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when results are valid.
- tt  out  128  captured truth table; held until the next accepted start.
- match  out  1  tt == latched expected; valid from done, held.
- mismatch_cnt  out  8  number of differing bits (0..128).
- first_bad  out  7  lowest minterm index that differs; 0 if none.
- first_bad_vld  out  1  at least one mismatch.
- ones_cnt  out  8  popcount of tt (0..128).

## Operation
- States: IDLE, RUN, DONE.
- IDLE -> RUN on start. On the same edge: latch expected; clear tt, counters and flags; set idx=0.
- RUN: x = idx. Each edge captures f_in into tt[idx] and updates the counters:
  - ones_cnt += f_in.
  - On mismatch, mismatch_cnt increments.
  - On the first mismatch, first_bad=idx and first_bad_vld=1.
  - idx then increments.
- At idx=127 the capture completes and the state moves to DONE. idx never wraps inside a sweep.
- DONE lasts one cycle: done=1, busy=0, match = (mismatch_cnt==0). Then back to IDLE.
- start while busy or in DONE is ignored and not queued.
- Counters are 8 bits and cannot overflow; the maximum is 128.

## Timing
- Reset values: x0..x6=0, busy=0, done=0, tt=0, match=0, mismatch_cnt=0, first_bad=0, first_bad_vld=0, ones_cnt=0. State is IDLE.
- Reset mid-sweep discards all partial results. Outputs return to their reset values on the next edge.
- Start accepted at edge E0:
  - busy=1 from E0.
  - Minterm k is driven during cycle k after E0 and captured at edge E(k+1).
  - done is high during the cycle following E128 (E0+128 edges).
- Total latency from start to done: 129 cycles.
- f_in must settle within one clock period of an x change, since the function block is purely combinational.
- Results remain stable from done until the next accepted start. A new start may be accepted in the cycle after done.

## Configuration
- TT_SWEEP_FREG_EN defined:
  - f_in passes through one register before comparison, for deep networks that would otherwise limit clock frequency.
  - RUN lasts 129 capture edges; the compare index lags the drive index by one.
  - Start-to-done latency is 130 cycles.
  - After the final minterm x holds at 127 for one extra cycle.
- TT_SWEEP_FREG_EN undefined: f_in is sampled directly, with 129-cycle latency as specified above.
- All other behaviour is identical in both builds.

## Test plan
- Function block = constant 0, expected=0: done at start+129; match=1, ones_cnt=0, mismatch_cnt=0, first_bad_vld=0.
- Function block = x0, expected=0xAAAA_..._AAAA: tt equals expected, match=1, ones_cnt=64.
- Function block = x0&x1, expected=0x8888_..._8888 with bit 5 also set: match=0, mismatch_cnt=1, first_bad=5, first_bad_vld=1, ones_cnt=32.
- Function block = constant 1, expected=0: mismatch_cnt=128, first_bad=0, ones_cnt=128, with no counter overflow.
- start pulsed again at cycle 40 of a sweep: ignored, and done occurs exactly once at the original time. Change expected mid-sweep: no effect, because expected was latched at start.
- rst asserted at RUN cycle 60: next edge gives IDLE with all outputs at reset values. A fresh start then gives a full 129-cycle sweep with correct results.
